// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency meter measurement sequencer: FSM
// encoding, range codes, gate-length table and the auto-range step rule.
package freq_meas_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ARM   = 3'd2,
    GATE  = 3'd3,
    LATCH = 3'd4,
    HOLD  = 3'd5
  } state_t;

  localparam logic [1:0] RNG_10MS  = 2'd0;
  localparam logic [1:0] RNG_100MS = 2'd1;
  localparam logic [1:0] RNG_1S    = 2'd2;
  localparam logic [1:0] RNG_10S   = 2'd3;

  // Gate length in 1 us ticks for each range code.
  function automatic int unsigned gate_len(input logic [1:0] r);
    int unsigned len;
    case (r)
      RNG_10MS:  len = 10_000;
      RNG_100MS: len = 100_000;
      RNG_1S:    len = 1_000_000;
      default:   len = 10_000_000;
    endcase
    return len;
  endfunction

  // Overflow steps toward shorter gates, a small count steps toward longer
  // ones; the ends saturate so the range never wraps.
  function automatic logic [1:0] next_range(input logic [1:0] r,
                                            input logic       ovf,
                                            input logic       msd_zero);
    logic [1:0] n;
    n = r;
    if (ovf) begin
      if (r != RNG_10MS) n = r - 2'd1;
    end else if (msd_zero && (r != RNG_10S)) begin
      n = r + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Tick counter shared by the gate and hold intervals: cleared by load,
// advanced by tick while enabled, done flags the tick that reaches term.
module gate_timer #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic         tick,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && tick) begin
      count <= count + 1'b1;
    end
  end

  assign done = en && tick && (count == term);

endmodule

// File: rtl/freq_gate_sequencer.sv
// Measurement controller: sequences clear, gate, latch and display hold for the
// BCD edge counter with a four-range, optionally auto-ranged gate time.
module freq_gate_sequencer
  import freq_meas_pkg::*;
#(
  parameter int unsigned GATE_W   = 24,
  parameter int unsigned HOLD_US  = 200_000,
  parameter int unsigned GATE_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1us,
  input  logic [1:0] gate_sel,
  input  logic       auto_range,
  input  logic       single,
  input  logic       start,
  input  logic       cnt_carry,
  input  logic       cnt_msd_zero,
  output logic       cnt_clear,
  output logic       cnt_gate,
  output logic       latch,
  output logic       overflow,
  output logic [1:0] range,
  output logic [2:0] dp_pos,
  output logic       busy,
  output state_t     fsm_state
);

  // Terminal counts are length-1 because the timer starts at zero.
  localparam logic [GATE_W-1:0] TERM_R0   = GATE_W'(gate_len(RNG_10MS)  / GATE_DIV - 1);
  localparam logic [GATE_W-1:0] TERM_R1   = GATE_W'(gate_len(RNG_100MS) / GATE_DIV - 1);
  localparam logic [GATE_W-1:0] TERM_R2   = GATE_W'(gate_len(RNG_1S)    / GATE_DIV - 1);
  localparam logic [GATE_W-1:0] TERM_R3   = GATE_W'(gate_len(RNG_10S)   / GATE_DIV - 1);
  localparam logic [GATE_W-1:0] HOLD_TERM = GATE_W'(HOLD_US - 1);

  state_t            state;
  state_t            state_next;
  logic [1:0]        cur_rng;
  logic              rng_valid;
  logic              auto_lock;
  logic              ovf_sticky;
  logic [GATE_W-1:0] gate_term;
  logic [GATE_W-1:0] timer_term;
  logic              timer_load;
  logic              timer_en;
  logic              timer_done;

  always_comb begin
    gate_term = TERM_R0;
    unique case (cur_rng)
      RNG_10MS:  gate_term = TERM_R0;
      RNG_100MS: gate_term = TERM_R1;
      RNG_1S:    gate_term = TERM_R2;
      RNG_10S:   gate_term = TERM_R3;
    endcase
  end

  assign timer_term = (state == HOLD) ? HOLD_TERM : gate_term;
  assign timer_load = (state == CLEAR) || (state == LATCH);
  assign timer_en   = (state == GATE) || (state == HOLD);

  gate_timer #(
    .W (GATE_W)
  ) u_gate_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .tick (tick_1us),
    .term (timer_term),
    .done (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!single || start) state_next = CLEAR;
      CLEAR:   state_next = ARM;
      ARM:     if (tick_1us) state_next = GATE;
      GATE:    if (timer_done) state_next = LATCH;
      LATCH:   state_next = HOLD;
      HOLD:    if (timer_done) state_next = single ? IDLE : CLEAR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_clear = (state == CLEAR);
    cnt_gate  = (state == GATE);
    latch     = (state == LATCH);
    busy      = (state != IDLE);
  end

  assign fsm_state = state;

  // auto_range is captured at CLEAR so a mid-cycle change cannot alter the
  // step taken at this cycle's latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_rng    <= RNG_10MS;
      rng_valid  <= 1'b0;
      auto_lock  <= 1'b0;
      ovf_sticky <= 1'b0;
      overflow   <= 1'b0;
      range      <= RNG_10MS;
      dp_pos     <= 3'd1;
    end else begin
      unique case (state)
        IDLE: begin
          rng_valid <= 1'b0;
        end
        CLEAR: begin
          ovf_sticky <= 1'b0;
          auto_lock  <= auto_range;
          rng_valid  <= 1'b1;
          if (!auto_range || !rng_valid) cur_rng <= gate_sel;
        end
        GATE: begin
          if (cnt_carry) ovf_sticky <= 1'b1;
        end
        LATCH: begin
          overflow <= ovf_sticky;
          range    <= cur_rng;
          dp_pos   <= {1'b0, cur_rng} + 3'd1;
          if (auto_lock) cur_rng <= next_range(cur_rng, ovf_sticky, cnt_msd_zero);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
